// File: rtl/pot_smoother.sv
// pot_smoother
// Conditions the two-channel potentiometer ADC words before the frequency
// converter. Each conversion-valid rising edge (after synchronisation) pushes
// one sample per channel into a power-of-two ring buffer with a running sum.
// The average of the channel chosen by sel passes through a hysteresis filter
// to give a stable cutoff word plus a one-cycle change strobe.
//
// Ports:
//   clk        in   1           single 50 MHz clock, rising edge
//   reset_n    in   1           asynchronous active-low reset
//   adc_in     in   CHANNELS*N  packed pot words, channel c at [c*N +: N]
//   valid      in   1           conversion-ready level, asynchronous
//   sel        in   SW          channel select (0 = LPF pot, 1 = HPF pot), asynchronous
//   pot_out    out  N           smoothed, hysteresis-held word of selected channel
//   pot_strobe out  1           one-cycle pulse when pot_out takes a new value
//   primed     out  1           high once the first sample after reset is captured
module pot_smoother #(
    parameter int N        = 10,
    parameter int CHANNELS = 2,
    parameter int AVG_LOG2 = 3,
    parameter int HYST     = 4,
    localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CHANNELS*N-1:0] adc_in,
    input  logic                  valid,
    input  logic [SW-1:0]         sel,
    output logic [N-1:0]          pot_out,
    output logic                  pot_strobe,
    output logic                  primed
);

    localparam int          DEPTH   = 1 << AVG_LOG2;
    localparam int          SUMW    = N + AVG_LOG2;
    localparam logic [N-1:0] HYST_W  = N'(HYST);
    localparam logic [N-1:0] RAIL_HI = {N{1'b1}};

    typedef enum logic [0:0] {
        ST_UNPRIMED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    logic                valid_meta_r, valid_sync_r, valid_d_r;
    logic [SW-1:0]       sel_meta_r, sel_sync_r, sel_d_r;
    logic                capture_s;
    logic                sel_chg_s;
    logic                cap_done_r;
    logic                primed_r;
    logic [AVG_LOG2-1:0] ptr_r;
    logic [N-1:0]        ring_r [CHANNELS][DEPTH];
    logic [SUMW-1:0]     sum_r  [CHANNELS];
    logic [N-1:0]        avg_s  [CHANNELS];
    logic [N-1:0]        avg_sel_s;
    logic [N-1:0]        diff_s;
    logic                hyst_upd_s;
    logic                rail_upd_s;
    state_t              state_r, state_nxt_s;
    logic [N-1:0]        pot_r, pot_nxt_s;
    logic                strobe_r, strobe_nxt_s;

    // Two-flop synchronisers for valid and sel, plus one delay stage each for edge/change detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_meta_r <= 1'b0;
            valid_sync_r <= 1'b0;
            valid_d_r    <= 1'b0;
            sel_meta_r   <= '0;
            sel_sync_r   <= '0;
            sel_d_r      <= '0;
        end else begin
            valid_meta_r <= valid;
            valid_sync_r <= valid_meta_r;
            valid_d_r    <= valid_sync_r;
            sel_meta_r   <= sel;
            sel_sync_r   <= sel_meta_r;
            sel_d_r      <= sel_sync_r;
        end
    end

    // A held-high valid produces exactly one event; only the rising edge counts.
    assign capture_s = valid_sync_r & ~valid_d_r;
    assign sel_chg_s = (sel_sync_r != sel_d_r);

    // Capture stage: first sample floods the whole window so the average starts
    // at the real value; afterwards one shared pointer walks the ring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_done_r <= 1'b0;
            primed_r   <= 1'b0;
            ptr_r      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sum_r[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    ring_r[c][d] <= '0;
                end
            end
        end else begin
            cap_done_r <= capture_s;
            if (capture_s) begin
                if (!primed_r) begin
                    primed_r <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        sum_r[c] <= {adc_in[c*N +: N], {AVG_LOG2{1'b0}}};
                        for (int d = 0; d < DEPTH; d++) begin
                            ring_r[c][d] <= adc_in[c*N +: N];
                        end
                    end
                end else begin
                    ptr_r <= ptr_r + AVG_LOG2'(1);
                    for (int c = 0; c < CHANNELS; c++) begin
                        ring_r[c][ptr_r] <= adc_in[c*N +: N];
                        // Sum keeps AVG_LOG2 guard bits, so it can never overflow.
                        sum_r[c] <= sum_r[c] + SUMW'(adc_in[c*N +: N]) - SUMW'(ring_r[c][ptr_r]);
                    end
                end
            end
        end
    end

    // Per-channel truncated average and the selected one; out-of-range sel reads as zero.
    always_comb begin
        avg_sel_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            avg_s[c]  = sum_r[c][SUMW-1:AVG_LOG2];
            avg_sel_s = (sel_sync_r == SW'(c)) ? avg_s[c] : avg_sel_s;
        end
    end

    assign diff_s     = (avg_sel_s >= pot_r) ? (avg_sel_s - pot_r) : (pot_r - avg_sel_s);
    assign hyst_upd_s = (diff_s > HYST_W);
    // Rails must stay reachable even when they lie inside the hysteresis band.
    assign rail_upd_s = ((avg_sel_s == {N{1'b0}}) || (avg_sel_s == RAIL_HI)) && (avg_sel_s != pot_r);

    // Output FSM next state: first capture, then sel change, then hysteresis update.
    always_comb begin
        state_nxt_s  = state_r;
        pot_nxt_s    = pot_r;
        strobe_nxt_s = 1'b0;
        case (state_r)
            ST_UNPRIMED: begin
                if (cap_done_r) begin
                    state_nxt_s  = ST_RUN;
                    pot_nxt_s    = avg_sel_s;
                    strobe_nxt_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_UNPRIMED;
                end
            end
            ST_RUN: begin
                if (sel_chg_s) begin
                    pot_nxt_s    = avg_sel_s;
                    strobe_nxt_s = 1'b1;
                end else if (cap_done_r && (hyst_upd_s || rail_upd_s)) begin
                    pot_nxt_s    = avg_sel_s;
                    strobe_nxt_s = 1'b1;
                end else begin
                    pot_nxt_s    = pot_r;
                    strobe_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s  = ST_UNPRIMED;
                pot_nxt_s    = '0;
                strobe_nxt_s = 1'b0;
            end
        endcase
    end

    // Output FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_UNPRIMED;
            pot_r    <= '0;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pot_r    <= pot_nxt_s;
            strobe_r <= strobe_nxt_s;
        end
    end

    assign pot_out    = pot_r;
    assign pot_strobe = strobe_r;
    assign primed     = primed_r;

endmodule

// File: tb/tb_pot_smoother.sv
// Directed bench for pot_smoother with hand-computed expected values
// (N=10, two channels, window of 8 samples, hysteresis 4 LSB).
module tb_pot_smoother;

    localparam int N = 10;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [2*N-1:0] adc_in = '0;
    logic           valid = 1'b0;
    logic [0:0]     sel = 1'b0;
    logic [N-1:0]   pot_out;
    logic           pot_strobe;
    logic           primed;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobes      = 0;

    // Hand-computed pot_out after each sample of the sequences below.
    int exp_up520 [8] = '{512, 512, 512, 512, 517, 517, 517, 517};
    int stb_up520 [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int exp_dn0   [8] = '{455, 390, 325, 260, 195, 130, 65, 0};
    int exp_up1023[8] = '{127, 255, 383, 511, 639, 767, 895, 1023};
    int exp_dn1023[8] = '{895, 767, 639, 511, 383, 255, 127, 0};
    int rail_in   [10] = '{80, 24, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_rail  [10] = '{10, 10, 10, 10, 10, 10, 10, 10, 3, 0};
    int stb_rail  [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    always #5 clk = ~clk;

    pot_smoother #(.N(N), .CHANNELS(2), .AVG_LOG2(3), .HYST(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_in     (adc_in),
        .valid      (valid),
        .sel        (sel),
        .pot_out    (pot_out),
        .pot_strobe (pot_strobe),
        .primed     (primed)
    );

    task automatic chk_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock, observed on the falling edge; counts strobes seen.
    task automatic step();
        @(negedge clk);
        if (pot_strobe) strobes++;
    endtask

    // One conversion: valid high 2 clocks, then low long enough to settle.
    task automatic send(input int c0, input int c1);
        adc_in  = {N'(c1), N'(c0)};
        valid   = 1'b1;
        strobes = 0;
        repeat (2) step();
        valid = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_eq("rst_pot", pot_out, 0);
        chk_eq("rst_strobe", pot_strobe, 0);
        chk_eq("rst_primed", primed, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // First capture and its latency: strobe on the 4th edge counting the sampling edge
        adc_in  = {N'(100), N'(512)};
        valid   = 1'b1;
        strobes = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (pot_strobe) strobes++;
            if (i == 2) valid = 1'b0;
            if (i == 3) chk_eq("prime_primed", primed, 1);
            chk_eq($sformatf("lat_strobe_%0d", i), pot_strobe, (i == 4) ? 1 : 0);
            if (i == 4) chk_eq("prime_pot", pot_out, 512);
        end
        chk_eq("prime_strobes", strobes, 1);
        repeat (2) step();

        // Slow climb towards 520: hold while |diff| <= 4 (equality included)
        for (int k = 0; k < 8; k++) begin
            send(520, 100);
            chk_eq($sformatf("up520_pot_%0d", k), pot_out, exp_up520[k]);
            chk_eq($sformatf("up520_stb_%0d", k), strobes, stb_up520[k]);
        end

        // Step to zero, ramp to full scale, back to zero
        for (int k = 0; k < 8; k++) begin
            send(0, 100);
            chk_eq($sformatf("dn0_pot_%0d", k), pot_out, exp_dn0[k]);
            chk_eq($sformatf("dn0_stb_%0d", k), strobes, 1);
        end
        for (int k = 0; k < 8; k++) begin
            send(1023, 100);
            chk_eq($sformatf("up1023_pot_%0d", k), pot_out, exp_up1023[k]);
        end
        for (int k = 0; k < 8; k++) begin
            send(0, 100);
            chk_eq($sformatf("dn1023_pot_%0d", k), pot_out, exp_dn1023[k]);
        end

        // Rail inside the hysteresis band: 3 -> 0 must still update
        for (int k = 0; k < 10; k++) begin
            send(rail_in[k], 100);
            chk_eq($sformatf("rail_pot_%0d", k), pot_out, exp_rail[k]);
            chk_eq($sformatf("rail_stb_%0d", k), strobes, stb_rail[k]);
        end

        // Channel switch to HPF pot and back, unconditional update
        sel = 1'b1;
        strobes = 0;
        repeat (3) step();
        chk_eq("sel1_pot", pot_out, 100);
        chk_eq("sel1_stb", strobes, 1);
        repeat (2) step();
        send(8, 100);
        chk_eq("sel1_hold_pot", pot_out, 100);
        chk_eq("sel1_hold_stb", strobes, 0);
        sel = 1'b0;
        strobes = 0;
        repeat (3) step();
        chk_eq("sel0_pot", pot_out, 1);
        chk_eq("sel0_stb", strobes, 1);
        repeat (2) step();

        // valid held high for 20 clocks -> one capture only
        adc_in  = {N'(100), N'(800)};
        valid   = 1'b1;
        strobes = 0;
        repeat (20) step();
        valid = 1'b0;
        repeat (6) step();
        chk_eq("held_pot", pot_out, 101);
        chk_eq("held_stb", strobes, 1);

        // Two pulses separated by a 2-clock low -> two captures
        strobes = 0;
        valid = 1'b1;
        repeat (2) step();
        valid = 1'b0;
        repeat (2) step();
        valid = 1'b1;
        repeat (2) step();
        valid = 1'b0;
        repeat (6) step();
        chk_eq("pair_pot", pot_out, 301);
        chk_eq("pair_stb", strobes, 2);

        // Asynchronous reset mid-run, then full re-prime from a fresh sample
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("mid_rst_pot", pot_out, 0);
        chk_eq("mid_rst_primed", primed, 0);
        chk_eq("mid_rst_strobe", pot_strobe, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        send(300, 100);
        chk_eq("reprime_pot", pot_out, 300);
        chk_eq("reprime_primed", primed, 1);
        chk_eq("reprime_stb", strobes, 1);
        sel = 1'b1;
        strobes = 0;
        repeat (5) step();
        chk_eq("reprime_ch1_pot", pot_out, 100);
        chk_eq("reprime_ch1_stb", strobes, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
